// File: rtl/posit_pkg.sv
// Shared widths, special encodings and the decoded-operand record for the posit datapath.
package posit_pkg;

    localparam int unsigned N  = 32;
    localparam int unsigned ES = 4;
    localparam int unsigned RS = $clog2(N);
    localparam int unsigned SW = RS + ES + 2;   // signed scale width
    localparam int unsigned MW = N - ES - 1;    // mantissa width including hidden one
    localparam int unsigned PW = 2 * MW;        // exact mantissa product width

    localparam logic [N-1:0] POSIT_ZERO   = '0;
    localparam logic [N-1:0] POSIT_NAR    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] POSIT_MAXPOS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] POSIT_MINPOS = {{(N-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic          sign;
        logic          is_zero;
        logic          is_nar;
        logic [SW-1:0] scale;
        logic [MW-1:0] mantissa;
    } decoded_t;

endpackage

// File: rtl/posit_decode.sv
// Splits one posit word into sign, special flags, signed scale and hidden-one mantissa.
module posit_decode #(
    parameter int unsigned N  = 32,
    parameter int unsigned ES = 4
) (
    input  logic [N-1:0]            posit_i,
    output logic                    sign_o,
    output logic                    is_zero_o,
    output logic                    is_nar_o,
    output logic [$clog2(N)+ES+1:0] scale_o,
    output logic [N-ES-2:0]         mant_o
);

    localparam int unsigned RS = $clog2(N);
    localparam int unsigned KW = RS + 2;
    localparam int unsigned FB = N - ES - 2;

    logic [N-2:0]  body;
    logic [N-2:0]  run_bits;
    logic [N-3:0]  tail;
    logic          regime_bit;
    logic [RS-1:0] run;
    logic [KW-1:0] k;

    assign sign_o    = posit_i[N-1];
    assign is_zero_o = (posit_i == '0);
    assign is_nar_o  = (posit_i == {1'b1, {(N-1){1'b0}}});

    // Magnitude bits below the sign; negation only depends on these bits.
    assign body       = sign_o ? (~posit_i[N-2:0] + (N-1)'(1)) : posit_i[N-2:0];
    assign regime_bit = body[N-2];
    assign run_bits   = regime_bit ? ~body : body;

    // Leading-zero count of run_bits gives the regime run length.
    always_comb begin : lzc
        run = RS'(N - 1);
        for (int i = 0; i <= int'(N) - 2; i++) begin
            if (run_bits[i]) begin
                run = RS'(int'(N) - 2 - i);
            end
        end
    end

    assign k = regime_bit ? (KW'(run) - KW'(1)) : (KW'(0) - KW'(run));

    // First regime bit is already dropped, so shifting by run removes the rest plus the terminator.
    assign tail = body[N-3:0] << run;

    assign scale_o = {k, tail[N-3 -: ES]};
    assign mant_o  = {1'b1, tail[N-3-ES -: FB]};

endmodule

// File: rtl/posit_multiplier.sv
// Posit multiplier: exact mantissa product, round-to-nearest-even re-encode, one output register.
module posit_multiplier
    import posit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] IN1,
    input  logic [N-1:0] IN2,
    output logic [N-1:0] OUT
);

    localparam int unsigned KW = SW - ES;
    localparam int unsigned FW = PW - 1;
    localparam int unsigned EW = 2 + ES + FW + N;
    localparam logic signed [KW-1:0] K_HI = KW'(N - 2);
    localparam logic signed [KW-1:0] K_LO = -K_HI;

    decoded_t dec_a;
    decoded_t dec_b;

    posit_decode #(.N(N), .ES(ES)) u_dec_a (
        .posit_i   (IN1),
        .sign_o    (dec_a.sign),
        .is_zero_o (dec_a.is_zero),
        .is_nar_o  (dec_a.is_nar),
        .scale_o   (dec_a.scale),
        .mant_o    (dec_a.mantissa)
    );

    posit_decode #(.N(N), .ES(ES)) u_dec_b (
        .posit_i   (IN2),
        .sign_o    (dec_b.sign),
        .is_zero_o (dec_b.is_zero),
        .is_nar_o  (dec_b.is_nar),
        .scale_o   (dec_b.scale),
        .mant_o    (dec_b.mantissa)
    );

    logic [PW-1:0]        prod;
    logic                 ovf;
    logic [FW-1:0]        frac;
    logic [SW-1:0]        scale;
    logic signed [KW-1:0] k;
    logic [KW-1:0]        amt;
    logic [ES-1:0]        e;
    logic [EW-1:0]        seed;
    logic [EW-1:0]        shifted;
    logic [N-2:0]         body;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [N-1:0]         mag;
    logic [N-1:0]         result_d;
    logic [N-1:0]         out_q;

    assign prod  = PW'(dec_a.mantissa) * PW'(dec_b.mantissa);
    assign ovf   = prod[PW-1];
    assign frac  = ovf ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    assign scale = dec_a.scale + dec_b.scale + SW'(ovf);
    assign k     = scale[SW-1:ES];
    assign e     = scale[ES-1:0];

    // Seed "10" (k>=0) or "01" (k<0); shifting in copies of the leading bit grows the regime.
    assign amt     = k[KW-1] ? ~k : k;
    assign seed    = {~k[KW-1], k[KW-1], e, frac, N'(0)};
    assign shifted = EW'({{EW{~k[KW-1]}}, seed} >> amt);

    assign body     = shifted[EW-1 -: N-1];
    assign guard    = shifted[EW-N];
    assign sticky   = |shifted[EW-N-1:0];
    assign round_up = guard & (sticky | body[0]);

    always_comb begin : encode
        mag      = {1'b0, body + (N-1)'(round_up)};
        result_d = POSIT_ZERO;
        if (k >= K_HI) begin
            mag = POSIT_MAXPOS;
        end else if (k < K_LO) begin
            mag = POSIT_MINPOS;
        end
        if (dec_a.is_nar || dec_b.is_nar) begin
            result_d = POSIT_NAR;
        end else if (dec_a.is_zero || dec_b.is_zero) begin
            result_d = POSIT_ZERO;
        end else if (dec_a.sign ^ dec_b.sign) begin
            result_d = ~mag + N'(1);
        end else begin
            result_d = mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= POSIT_ZERO;
        end else begin
            out_q <= result_d;
        end
    end

    assign OUT = out_q;

endmodule

// File: tb/tb_posit_multiplier.sv
// Directed and random bench for posit_multiplier with a bit-serial posit<32,4> reference model.
module tb_posit_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] out;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] prev_exp;

    always #5 clk = ~clk;

    posit_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .IN1   (in1),
        .IN2   (in2),
        .OUT   (out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Reference decode: walks the bits one at a time.
    function automatic void ref_decode(input logic [31:0] p, output int scale,
                                       output longint unsigned sig, output int fbits);
        logic [31:0] m;
        int i, run, k, e;
        bit r;
        m = p[31] ? -p : p;
        i = 30;
        r = m[30];
        run = 0;
        while (i >= 0 && m[i] == r) begin
            run++;
            i--;
        end
        i--;
        k = r ? run - 1 : -run;
        e = 0;
        for (int j = 0; j < 4; j++) begin
            e = e * 2 + ((i >= 0) ? int'(m[i]) : 0);
            i--;
        end
        sig = 1;
        fbits = 0;
        while (i >= 0) begin
            sig = sig * 2 + longint'(m[i]);
            fbits++;
            i--;
        end
        scale = k * 16 + e;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int sa, sb, fa, fb, scale, msb, k, e;
        longint unsigned ga, gb, prod;
        bit q[$];
        logic [30:0] body;
        bit guard, sticky;
        logic [31:0] mag;
        if (a == 32'h8000_0000 || b == 32'h8000_0000) return 32'h8000_0000;
        if (a == 32'h0 || b == 32'h0) return 32'h0;
        ref_decode(a, sa, ga, fa);
        ref_decode(b, sb, gb, fb);
        prod = ga * gb;
        msb = 63;
        while (prod[msb] == 1'b0) msb--;
        scale = sa + sb + msb - (fa + fb);
        k = scale >>> 4;
        e = scale - 16 * k;
        if (k >= 30) begin
            mag = 32'h7FFF_FFFF;
        end else if (k <= -31) begin
            mag = 32'h0000_0001;
        end else begin
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int j = 3; j >= 0; j--) q.push_back(e[j]);
            for (int j = msb - 1; j >= 0; j--) q.push_back(prod[j]);
            body = '0;
            guard = 1'b0;
            sticky = 1'b0;
            foreach (q[j]) begin
                if (j < 31) body[30-j] = q[j];
                else if (j == 31) guard = q[j];
                else sticky |= q[j];
            end
            if (guard && (sticky || body[0])) body = body + 31'd1;
            mag = {1'b0, body};
        end
        return (a[31] ^ b[31]) ? -mag : mag;
    endfunction

    // Drive one operand pair; the previous result must hold until the edge, then the new one appears.
    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input string tag);
        in1 = a;
        in2 = b;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        #2;
        check({tag, "_hold"}, out, prev_exp);
        @(posedge clk);
        #1;
        prev_exp = exp_q[0];
        check(tag_q.pop_front(), out, exp_q.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, a, b;
        rst_n = 1'b0;
        in1 = 32'h4954_A722;
        in2 = 32'h4954_A722;
        prev_exp = 32'h0;
        #1;
        check("reset_state", out, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold_edges", out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step(32'h8000_0000, 32'hA92A_A456, 32'h8000_0000, "nar_a");
        step(32'h4954_A722, 32'h8000_0000, 32'h8000_0000, "nar_b");
        step(32'h0000_0000, 32'h54AA_A545, 32'h0000_0000, "zero_a");
        step(32'h4954_A722, 32'h0000_0000, 32'h0000_0000, "zero_b");
        step(32'h0000_0000, 32'h8000_0000, 32'h8000_0000, "zero_nar");
        step(32'h7FC0_0000, 32'h7FC0_0000, 32'h7FFF_C000, "large_pos");
        step(32'h8040_0000, 32'h8040_0000, 32'h7FFF_C000, "neg_neg");
        step(32'h7FC0_0000, 32'h8040_0000, 32'h8000_4000, "mixed_sign");
        step(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "maxpos_sq");
        step(32'h0000_0001, 32'h0000_0001, 32'h0000_0001, "minpos_sq");
        step(32'h7FFF_FFFF, 32'h0000_0001, 32'h4000_0000, "max_x_min");
        step(32'h8000_0001, 32'h8000_0001, 32'h7FFF_FFFF, "negmax_sq");
        step(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, "one_sq");
        step(32'h4000_0000, 32'hC000_0000, 32'hC000_0000, "one_x_minus_one");

        for (int i = 0; i < 20; i++) begin
            x = $urandom();
            if (x == 32'h8000_0000) x = 32'h1234_5678;
            step(32'h4000_0000, x, x, "one_x");
            step(x, 32'h4000_0000, x, "x_one");
        end

        step(32'h7FC0_0000, 32'h7FC0_0000, 32'h7FFF_C000, "pre_reset");
        in1 = 32'h4954_A722;
        in2 = 32'h54AA_A545;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset", out, 32'h0);
        @(posedge clk);
        #1;
        check("reset_discards", out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_exp = 32'h0;

        for (int i = 0; i < 300; i++) begin
            a = $urandom();
            b = $urandom();
            if (i % 3 == 1) a = a >> $urandom_range(0, 30);
            if (i % 3 == 2) b = ~(b >> $urandom_range(0, 30));
            if (i % 4 == 3) a = -a;
            step(a, b, ref_mul(a, b), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
